// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, fetch entry type and the empty/reset instruction value
package fetch_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_DATA_W-1:0] NOP_INSTR = '0;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, instr} FIFO with push/pop/clear and occupancy count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr,
  output logic [CW-1:0]     count
);
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Empty FIFO presents a NOP at pc 0 so decode never sees stale words
  always_comb begin
    head_pc = count != 0 ? mem_pc[rd_ptr] : '0;
    head_instr = count != 0 ? mem_instr[rd_ptr] : DATA_W'(NOP_INSTR);
  end

  // Storage and pointers; clear (flush) wins over push and pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i] <= '0;
        mem_instr[i] <= DATA_W'(NOP_INSTR);
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr] <= push_pc;
        mem_instr[wr_ptr] <= push_instr;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues 1-cycle imem reads for PC requests and buffers results for decode
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              fetch_stall,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [CW-1:0]     occupancy
);
  logic inflight_valid;
  logic [ADDR_W-1:0] last_addr;
  logic accept, push, pop;

  // Credit stall reserves a FIFO slot for the in-flight read; reset masks the strobe
  always_comb begin
    fetch_stall = (occupancy + CW'(inflight_valid)) >= CW'(DEPTH);
    accept = reset && pc_valid && !fetch_stall && !flush;
    imem_rd_en = accept;
    imem_addr = accept ? pc_addr : last_addr;
    push = inflight_valid && !flush;
    pop = instr_valid && instr_ready;
    instr_valid = occupancy != 0;
  end

  // In-flight stage; last_addr doubles as the pc of the outstanding read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_valid <= 1'b0;
      last_addr <= '0;
    end else begin
      inflight_valid <= accept;
      if (accept) last_addr <= pc_addr;
    end
  end

  fetch_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(flush),
    .push(push),
    .push_pc(last_addr),
    .push_instr(imem_rdata),
    .pop(pop),
    .head_pc(instr_pc),
    .head_instr(instr),
    .count(occupancy)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus checked every cycle against a queue-based fetch model
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic [31:0] pc_addr = 0, imem_rdata = 0;
  logic pc_valid = 0, flush = 0, instr_ready = 0;
  logic fetch_stall, imem_rd_en, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [2:0] occupancy;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .pc_addr(pc_addr), .pc_valid(pc_valid), .flush(flush),
    .fetch_stall(fetch_stall), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // instruction memory: word at address a is a+0x100, garbage when not read
  always @(posedge clk) imem_rdata <= imem_rd_en ? imem_addr + 32'h100 : 32'hDEADBEEF;

  int errs = 0, checks = 0, cyc = 0;
  logic [31:0] qp[$], qi[$], lp[$], li[$];
  int lc[$];
  logic pend = 0;
  logic [31:0] pend_pc = 0, m_last = 0;
  logic s_stall, s_rd;
  logic [2:0] s_occ;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // compare at negedge, log pops, advance model, move to posedge+1
  task automatic eval();
    logic e_stall, e_rd, e_valid;
    e_stall = rst_n && (qp.size() + int'(pend) >= DEPTH);
    e_rd = rst_n && pc_valid && !e_stall && !flush;
    e_valid = qp.size() != 0;
    chk("fetch_stall", fetch_stall, e_stall);
    chk("imem_rd_en", imem_rd_en, e_rd);
    chk("imem_addr", imem_addr, e_rd ? pc_addr : m_last);
    chk("instr_valid", instr_valid, e_valid);
    chk("occupancy", occupancy, qp.size());
    chk("instr_pc", instr_pc, e_valid ? qp[0] : 0);
    chk("instr", instr, e_valid ? qi[0] : 0);
    s_stall = fetch_stall; s_rd = imem_rd_en; s_occ = occupancy;
    if (instr_valid && instr_ready) begin lp.push_back(instr_pc); li.push_back(instr); lc.push_back(cyc); end
    if (!rst_n) begin
      qp.delete(); qi.delete(); pend = 0; m_last = 0;
    end else if (flush) begin
      qp.delete(); qi.delete(); pend = 0;
    end else begin
      if (e_valid && instr_ready) begin void'(qp.pop_front()); void'(qi.pop_front()); end
      if (pend) begin qp.push_back(pend_pc); qi.push_back(pend_pc + 32'h100); end
      pend = e_rd;
      if (e_rd) begin pend_pc = pc_addr; m_last = pc_addr; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic cycle(logic pv, logic [31:0] pa, logic fl, logic rdy);
    pc_valid = pv; pc_addr = pa; flush = fl; instr_ready = rdy;
    #4;
    eval();
  endtask

  task automatic clear_log();
    lp.delete(); li.delete(); lc.delete();
  endtask

  initial begin
    int s;
    @(posedge clk); #1;
    // reset held: requests are ignored and outputs stay zero
    cycle(1, 32'h7, 0, 1);
    cycle(1, 32'h8, 0, 1);
    chk("rst_rd_en", s_rd, 0);
    chk("rst_occ", s_occ, 0);
    rst_n = 1;
    // stream 0..3 with ready
    clear_log();
    s = cyc;
    for (int i = 0; i < 4; i++) cycle(1, i, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);
    chk("stream_n", lp.size(), 4);
    chk("stream_lat", lc[0], s + 2);
    for (int i = 0; i < 4; i++) begin
      chk("stream_pc", lp[i], i);
      chk("stream_instr", li[i], 32'h100 + i);
      chk("stream_b2b", lc[i], s + 2 + i);
    end
    // backpressure: 3 stored + 1 in flight stalls
    clear_log();
    for (int i = 0; i < 4; i++) cycle(1, 32'h20 + i, 0, 0);
    cycle(1, 32'h24, 0, 0);
    chk("stall_on", s_stall, 1);
    chk("stall_no_rd", s_rd, 0);
    cycle(1, 32'h25, 0, 0);
    chk("stall_occ4", s_occ, 4);
    cycle(0, 0, 0, 1);
    chk("full_pop_stall", s_stall, 1);
    cycle(0, 0, 0, 1);
    chk("stall_release", s_stall, 0);
    repeat (3) cycle(0, 0, 0, 1);
    chk("drain_n", lp.size(), 4);
    for (int i = 0; i < lp.size(); i++) chk("drain_pc", lp[i], 32'h20 + i);
    // flush with 3 buffered + 1 in flight, pc_valid in the flush cycle
    clear_log();
    for (int i = 0; i < 4; i++) cycle(1, 32'h30 + i, 0, 0);
    cycle(1, 32'h99, 1, 0);
    chk("flush_no_rd", s_rd, 0);
    chk("flush_occ_before", s_occ, 3);
    s = cyc;
    cycle(1, 32'h40, 0, 1);
    chk("post_flush_occ", s_occ, 0);
    repeat (3) cycle(0, 0, 0, 1);
    chk("flush_n", lp.size(), 1);
    chk("flush_pc", lp[0], 32'h40);
    chk("flush_instr", li[0], 32'h140);
    chk("flush_lat", lc[0], s + 2);
    // steady push+pop at occupancy 2 across pointer wrap
    clear_log();
    cycle(1, 32'h50, 0, 0);
    cycle(1, 32'h51, 0, 0);
    cycle(1, 32'h52, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'h53 + i, 0, 1);
      chk("steady_occ", s_occ, 2);
    end
    repeat (4) cycle(0, 0, 0, 1);
    chk("steady_n", lp.size(), 13);
    for (int i = 0; i < lp.size(); i++) chk("steady_pc", lp[i], 32'h50 + i);
    // async reset pulse between edges mid-stream
    cycle(1, 32'h60, 0, 0);
    cycle(1, 32'h61, 0, 0);
    pc_valid = 0; flush = 0; instr_ready = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_instr", instr, 0);
    chk("arst_pc", instr_pc, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_rd", imem_rd_en, 0);
    chk("arst_stall", fetch_stall, 0);
    qp.delete(); qi.delete(); pend = 0; m_last = 0;
    #1 rst_n = 1;
    #1;
    eval();
    clear_log();
    s = cyc;
    cycle(1, 32'h10, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);
    chk("arst_n", lp.size(), 1);
    chk("arst_first_pc", lp[0], 32'h10);
    chk("arst_first_instr", li[0], 32'h110);
    chk("arst_lat", lc[0], s + 2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-side consumer of the program counter's address stream. It accepts one PC word address per cycle and issues reads to synchronous instruction memory with fixed 1-cycle latency. Returned words are buffered with their PC in a small FIFO and presented to decode over a valid/ready handshake. A branch redirect flushes all buffered and in-flight fetches, matching the PC's branch-select event.

Parameters:
ADDR_W, 32, PC / instruction-memory word-address width
DATA_W, 32, instruction word width
DEPTH, 4, fetch FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
pc_addr  in  ADDR_W  word address from program counter
pc_valid  in  1  pc_addr is a fetch request this cycle
flush  in  1  branch redirect; same cycle as PC branch select
fetch_stall  out  1  block cannot accept a request this cycle
imem_rd_en  out  1  instruction-memory read strobe
imem_addr  out  ADDR_W  instruction-memory address
imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after imem_rd_en
instr  out  DATA_W  instruction at FIFO head
instr_pc  out  ADDR_W  PC of instr
instr_valid  out  1  head entry valid
instr_ready  in  1  decode accepts head entry
occupancy  out  $clog2(DEPTH)+1  current FIFO entry count

Behaviour:
- No explicit FSM. State: FIFO storage (DEPTH x {pc, instr}), rd/wr pointers, count, inflight_valid, inflight_pc.
- Reset (reset=0, async): pointers, count, inflight_valid, and all FIFO entries cleared. instr=0, instr_pc=0, instr_valid=0, occupancy=0, fetch_stall=0, imem_rd_en=0, imem_addr=0. Outputs hold these values while reset=0.
- fetch_stall is combinational: (count + inflight_valid) >= DEPTH. This credit scheme guarantees a FIFO slot for every issued read.
- Accept condition: pc_valid && !fetch_stall && !flush.
  - On accept: imem_rd_en=1 and imem_addr=pc_addr, both combinational in the same cycle.
  - Otherwise imem_rd_en=0 and imem_addr holds its last accepted value.
- On accept, set inflight_valid=1 and inflight_pc=pc_addr at the clock edge. Otherwise clear inflight_valid.
- Return: in the cycle where inflight_valid=1 and flush=0, {inflight_pc, imem_rdata} is written to the FIFO at the edge.
- Latency: request accepted in cycle N, instr_valid=1 with that word in cycle N+2. Sustained throughput is 1 instr/cycle while instr_ready=1.
- Output: instr_valid = (count != 0). instr and instr_pc come from the head entry. Pop occurs on instr_valid && instr_ready.
- Push and pop may occur in the same cycle; count is unchanged. Pop is allowed when full, and stall releases the next cycle.
- Pointers wrap modulo DEPTH. count saturates at DEPTH by construction; overflow is impossible.
- Flush has priority over everything. At the edge it:
  - clears count and pointers;
  - clears inflight_valid and discards that cycle's imem_rdata;
  - suppresses any new request that cycle.
  - Next cycle: instr_valid=0, occupancy=0. The redirected pc_addr is accepted from the cycle after flush.
- Pop in the flush cycle: the decode handshake completes, then the FIFO clears.
- pc_valid while fetch_stall=1: request dropped, no read issued. The upstream must hold or replay.
- Reset mid-operation: in-flight data arriving after reset release is ignored, because inflight_valid=0.

Decomposition:
- fetch_pkg: ADDR_W/DATA_W defaults, fetch entry struct {pc, instr}, NOP_INSTR=0 constant used for reset/empty head value.
- One sub-module, fetch_fifo: synchronous FIFO with push/pop/clear, count output, async active-low reset. instr_fetch_unit holds the in-flight stage, credit stall, and flush logic.

Test Plan:
- Reset then stream pc_addr 0,1,2,3 with pc_valid=1, instr_ready=1, imem returning addr+0x100 → instr_valid rises 2 cycles after first request; outputs (pc, instr) = (0,0x100),(1,0x101),(2,0x102),(3,0x103) on consecutive cycles.
- instr_ready=0 while streaming, DEPTH=4 → fetch_stall=1 after 3 stored + 1 in flight; occupancy peaks at 4; no read issued while stalled; release ready → 4 entries drain in order, no loss or duplicate.
- Flush with 3 buffered and 1 in flight → next cycle instr_valid=0, occupancy=0; the in-flight word never appears; pc 0x40 requested after flush is delivered 2 cycles later as the first output.
- Simultaneous push and pop at occupancy=2 for 10 cycles → occupancy stays 2; pointer wrap verified (output order matches request order).
- Assert reset=0 asynchronously mid-stream (between clock edges) → all outputs 0 immediately; after release, a new request at pc 0x10 yields first instr_pc=0x10 with no stale data.
- pc_valid and flush both 1 in the same cycle → imem_rd_en=0 that cycle; no entry is created for that address.
